// File: rtl/fecha_rtc_writer.sv
// fecha_rtc_writer
//
// Writes an edited BCD date (day, month, year) into an external RTC over its
// multiplexed address/data bus. A rising edge on `commit` latches the three
// values and runs three register writes (day, month, year). Each write is
// seven bus phases of T_PH clocks: address setup/strobe/hold, data
// setup/strobe/hold, then a gap with the bus released. A one-cycle DONE state
// follows the last write. Every bus output comes straight from a register.
//
// Build option: define FECHA_VALIDATE_EN to reject commits whose date is not
// a plausible BCD calendar date. A rejected commit pulses `err` for one cycle
// and causes no bus activity. Without the macro `err` is constant 0.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   diaC    in   [7:0] day, BCD {tens,units}
//   mesC    in   [7:0] month, BCD
//   yearC   in   [7:0] year, BCD
//   commit  in   level; a rising edge requests a write-back
//   busy    out  write sequence in progress
//   done    out  one-cycle pulse at sequence end
//   err     out  one-cycle pulse on a rejected commit
//   cs_n    out  RTC chip select, active low
//   a_d     out  0 = address phase, 1 = data phase
//   wr_n    out  RTC write strobe, active low
//   rd_n    out  RTC read strobe, constant 1
//   ad_oe   out  bus driver enable
//   ad_out  out  [7:0] address/data bus value
module fecha_rtc_writer #(
    parameter int         T_PH      = 2,
    parameter logic [7:0] ADDR_DIA  = 8'h24,
    parameter logic [7:0] ADDR_MES  = 8'h25,
    parameter logic [7:0] ADDR_YEAR = 8'h26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] diaC,
    input  logic [7:0] mesC,
    input  logic [7:0] yearC,
    input  logic       commit,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad_oe,
    output logic [7:0] ad_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic       cs_n;
        logic       ad_oe;
        logic       a_d;
        logic       wr_n;
        logic [7:0] ad_out;
    } bus_t;

    localparam int            CW       = (T_PH > 1) ? $clog2(T_PH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(T_PH - 1);
    localparam bus_t          BUS_IDLE = '{cs_n: 1'b1, ad_oe: 1'b0, a_d: 1'b0,
                                           wr_n: 1'b1, ad_out: 8'h00};

    state_t        state;
    logic          commit_q;
    logic [CW-1:0] cnt;
    logic [2:0]    phase;
    logic [1:0]    idx;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    bus_t          bus_q;

    // Shadow copies of the date; only captured when a sequence starts.
    logic [7:0]    dia_s;
    logic [7:0]    mes_s;
    logic [7:0]    year_s;

    logic          commit_edge;
    logic          date_valid;
    logic          start;

    // Register address for write number i.
    function automatic logic [7:0] addr_for(input logic [1:0] i);
        case (i)
            2'd0:    return ADDR_DIA;
            2'd1:    return ADDR_MES;
            default: return ADDR_YEAR;
        endcase
    endfunction

    // Data byte for write number i.
    function automatic logic [7:0] data_for(input logic [1:0] i,
                                            input logic [7:0] d,
                                            input logic [7:0] m,
                                            input logic [7:0] y);
        case (i)
            2'd0:    return d;
            2'd1:    return m;
            default: return y;
        endcase
    endfunction

    // Bus pins for a given phase of one write. Phase 6 (gap) and anything
    // beyond release the bus.
    function automatic bus_t phase_bus(input logic [2:0] ph,
                                       input logic [7:0] addr,
                                       input logic [7:0] data);
        bus_t b;
        b = '{cs_n: 1'b0, ad_oe: 1'b1, a_d: 1'b0, wr_n: 1'b1, ad_out: addr};
        case (ph)
            3'd0: ;
            3'd1: b.wr_n = 1'b0;
            3'd2: ;
            3'd3: begin b.a_d = 1'b1; b.ad_out = data; end
            3'd4: begin b.a_d = 1'b1; b.ad_out = data; b.wr_n = 1'b0; end
            3'd5: begin b.a_d = 1'b1; b.ad_out = data; end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

`ifdef FECHA_VALIDATE_EN
    // Plausible BCD date: all nibbles decimal, month 01..12, day 01..31 and
    // limited by the month length (February allowed up to 29, no leap rule).
    function automatic logic date_ok(input logic [7:0] d,
                                     input logic [7:0] m,
                                     input logic [7:0] y);
        logic ok;
        ok = (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9) &&
             (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
             (y[7:4] <= 4'd9) && (y[3:0] <= 4'd9);
        // With decimal nibbles, BCD bytes compare in numeric order.
        ok = ok && (m >= 8'h01) && (m <= 8'h12);
        ok = ok && (d >= 8'h01) && (d <= 8'h31);
        if ((m == 8'h04) || (m == 8'h06) || (m == 8'h09) || (m == 8'h11))
            ok = ok && (d <= 8'h30);
        if (m == 8'h02)
            ok = ok && (d <= 8'h29);
        return ok;
    endfunction

    assign date_valid = date_ok(diaC, mesC, yearC);
`else
    assign date_valid = 1'b1;
`endif

    assign commit_edge = commit & ~commit_q;
    assign start       = (state == IDLE) && commit_edge && date_valid;

    always_ff @(posedge clk) begin
        if (start) begin
            dia_s  <= diaC;
            mes_s  <= mesC;
            year_s <= yearC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            commit_q <= 1'b0;
            cnt      <= '0;
            phase    <= 3'd0;
            idx      <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bus_q    <= BUS_IDLE;
        end else begin
            // The level is tracked even while busy, so a held commit never
            // produces a late edge.
            commit_q <= commit;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= WRITE;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        phase  <= 3'd0;
                        idx    <= 2'd0;
                        bus_q  <= phase_bus(3'd0, addr_for(2'd0), diaC);
                    end else if (commit_edge) begin
                        err_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (phase == 3'd6) begin
                            if (idx == 2'd2) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                idx   <= idx + 2'd1;
                                phase <= 3'd0;
                                bus_q <= phase_bus(3'd0, addr_for(idx + 2'd1),
                                                   data_for(idx + 2'd1, dia_s, mes_s, year_s));
                            end
                        end else begin
                            phase <= phase + 3'd1;
                            bus_q <= phase_bus(phase + 3'd1, addr_for(idx),
                                               data_for(idx, dia_s, mes_s, year_s));
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    bus_q  <= BUS_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign cs_n   = bus_q.cs_n;
    assign a_d    = bus_q.a_d;
    assign wr_n   = bus_q.wr_n;
    assign ad_oe  = bus_q.ad_oe;
    assign ad_out = bus_q.ad_out;
    assign rd_n   = 1'b1;

endmodule
